// File: rtl/serial_pattern_tx_if.sv
// Control and serial-stream bundle between a controller and serial_pattern_tx.
// The master drives the request side; the slave (transmitter) drives the stream.
interface serial_pattern_tx_if #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) ();
    logic             start;
    logic [WIDTH-1:0] data;
    logic [REP_W-1:0] reps;
    logic             abort;
    logic             p1;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, data, reps, abort,
        input  p1, valid, busy, done
    );

    modport slave (
        input  start, data, reps, abort,
        output p1, valid, busy, done
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// Repeating MSB-first serial pattern transmitter with optional inter-frame gap.
// All outputs are registered and decoded from the next state.
module serial_pattern_tx #(
    parameter int WIDTH      = 4,
    parameter int REP_W      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic               clk,
    input  logic               reset,
    serial_pattern_tx_if.slave bus
);
    localparam int BW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state, w_state;
    logic [WIDTH-1:0] r_shift, w_shift;
    logic [WIDTH-1:0] r_pat;
    logic [BW-1:0]    r_bit, w_bit;
    logic [REP_W-1:0] r_frames, w_frames;
    logic             r_p1, r_valid, r_busy, r_done;
    logic             w_accept;
    logic             w_frame_end;
    logic             w_gap_last;

    assign w_accept    = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_frame_end = (r_bit == BW'(WIDTH - 1));

    always_comb begin
        w_state  = r_state;
        w_shift  = r_shift;
        w_bit    = r_bit;
        w_frames = r_frames;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state  = S_SHIFT;
                    w_shift  = bus.data;
                    w_bit    = '0;
                    w_frames = (bus.reps == '0) ? REP_W'(1) : bus.reps;
                end
            end
            S_SHIFT: begin
                if (bus.abort) begin
                    w_state = S_IDLE;
                end else begin
                    w_shift = {r_shift[WIDTH-2:0], 1'b0};
                    w_bit   = r_bit + 1'b1;
                    if (w_frame_end) begin
                        w_bit    = '0;
                        w_frames = r_frames - 1'b1;
                        if (r_frames == REP_W'(1))
                            w_state = S_DONE;
                        else if (GAP_CYCLES > 0)
                            w_state = S_GAP;
                        else
                            w_shift = r_pat;
                    end
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    w_state = S_IDLE;
                end else if (w_gap_last) begin
                    w_state = S_SHIFT;
                    w_shift = r_pat;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_pat    <= '0;
            r_bit    <= '0;
            r_frames <= '0;
            r_p1     <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_shift  <= w_shift;
            r_bit    <= w_bit;
            r_frames <= w_frames;
            if (w_accept)
                r_pat <= bus.data;
            r_p1    <= (w_state == S_SHIFT) && w_shift[WIDTH-1];
            r_valid <= (w_state == S_SHIFT);
            r_busy  <= (w_state == S_SHIFT) || (w_state == S_GAP);
            r_done  <= (w_state == S_DONE);
        end
    end

    // Gap counter only exists when frames are separated by idle cycles.
    generate
        if (GAP_CYCLES > 0) begin : g_gap
            localparam int GW = $clog2(GAP_CYCLES + 1);
            logic [GW-1:0] r_gap;

            always_ff @(posedge clk) begin
                if (!reset)
                    r_gap <= '0;
                else if (r_state == S_GAP && !bus.abort && !w_gap_last)
                    r_gap <= r_gap + 1'b1;
                else
                    r_gap <= '0;
            end

            assign w_gap_last = (r_gap == GW'(GAP_CYCLES - 1));
        end else begin : g_nogap
            assign w_gap_last = 1'b1;
        end
    endgenerate

    assign bus.p1    = r_p1;
    assign bus.valid = r_valid;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: one back-to-back instance, one gapped.
// Expected waveforms are written as strings: 0/1 bit, '-' gap, 'D' done, '.' idle.
module tb_serial_pattern_tx;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_err;

    serial_pattern_tx_if #(.WIDTH(4), .REP_W(4)) a ();
    serial_pattern_tx_if #(.WIDTH(4), .REP_W(4)) b ();

    serial_pattern_tx #(.WIDTH(4), .REP_W(4), .GAP_CYCLES(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a)
    );

    serial_pattern_tx #(.WIDTH(4), .REP_W(4), .GAP_CYCLES(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] obs(input int sel);
        if (sel == 0)
            return {a.p1, a.valid, a.busy, a.done};
        return {b.p1, b.valid, b.busy, b.done};
    endfunction

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (p1,valid,busy,done)",
                   tag, got, exp);
        end
    endtask

    task automatic expect_seq(input string tag, input int sel,
                              input string s);
        for (int i = 0; i < s.len(); i++) begin
            logic [3:0] e;
            case (s[i])
                "1":     e = 4'b1110;
                "0":     e = 4'b0110;
                "-":     e = 4'b0010;
                "D":     e = 4'b0001;
                default: e = 4'b0000;
            endcase
            chk($sformatf("%s[%0d]", tag, i), obs(sel), e);
            tick();
        end
    endtask

    task automatic launch(input int sel, input logic [3:0] d,
                          input logic [3:0] r);
        if (sel == 0) begin
            a.start = 1'b1; a.data = d; a.reps = r;
        end else begin
            b.start = 1'b1; b.data = d; b.reps = r;
        end
        tick();
        a.start = 1'b0;
        b.start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset    = 1'b0;
        a.start = 1'b0; a.data = '0; a.reps = '0; a.abort = 1'b0;
        b.start = 1'b0; b.data = '0; b.reps = '0; b.abort = 1'b0;
        tick();
        tick();
        chk("reset_a", obs(0), 4'b0000);
        chk("reset_b", obs(1), 4'b0000);
        reset = 1'b1;
        tick();

        launch(0, 4'b1101, 4'd1);
        expect_seq("single", 0, "1101D.");

        launch(0, 4'b1101, 4'd3);
        expect_seq("b2b", 0, "110111011101D.");

        launch(1, 4'b1101, 4'd2);
        expect_seq("gapped", 1, "1101--1101D.");

        // reps=0 sends one frame; start in SHIFT and DONE is ignored
        launch(0, 4'b1101, 4'd0);
        expect_seq("rep0_c1", 0, "1");
        a.start = 1'b1; a.data = 4'b0000; a.reps = 4'd5;
        expect_seq("rep0_c2", 0, "101D");
        a.start = 1'b0;
        expect_seq("rep0_end", 0, "..");

        // abort and start together in IDLE: nothing starts
        a.start = 1'b1; a.abort = 1'b1; a.data = 4'b1111; a.reps = 4'd1;
        tick();
        a.start = 1'b0; a.abort = 1'b0;
        expect_seq("abort_idle", 0, "..");

        // abort mid-frame, then immediate restart
        launch(0, 4'b1101, 4'd3);
        expect_seq("abort_c1", 0, "1");
        a.abort = 1'b1;
        expect_seq("abort_c2", 0, "1");
        a.abort = 1'b0;
        chk("abort_c3", obs(0), 4'b0000);
        launch(0, 4'b1011, 4'd1);
        expect_seq("abort_restart", 0, "1011D..");

        // abort during the gap
        launch(1, 4'b1101, 4'd2);
        expect_seq("gabort", 1, "1101-");
        b.abort = 1'b1;
        tick();
        b.abort = 1'b0;
        expect_seq("gabort_idle", 1, "...");

        // reset mid-frame, then a fresh single frame
        launch(0, 4'b1101, 4'd3);
        expect_seq("rst_run", 0, "11");
        reset = 1'b0;
        expect_seq("rst_c3", 0, "0");
        expect_seq("rst_low", 0, "..");
        reset = 1'b1;
        expect_seq("rst_rel", 0, ".");
        launch(0, 4'b1101, 4'd1);
        expect_seq("rst_single", 0, "1101D.");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end
endmodule
